// File: rtl/bowling_pkg.sv
// Shared definitions for the bowling game datapath: game state encoding
// (also used by the aim, power and pin stages) and per-throw constants.
package bowling_pkg;

   typedef enum logic [1:0] {
      AIMPOWER    = 2'b00,
      CALCULATE   = 2'b01,
      UPDATE_GAME = 2'b10,
      GAME_OVER   = 2'b11
   } game_state_t;

   localparam logic [2:0] TARGET_SEED  = 3'b010;
   localparam logic [1:0] STRIKE_PINS  = 2'd3;
   localparam int         STRIKE_BONUS = 1;

endpackage

// File: rtl/game_sequencer_if.sv
// Handshake/status bundle between the game sequencer and its neighbours:
// per-throw events come in, game state and round control go out.
interface game_sequencer_if
   import bowling_pkg::*;
#(
   parameter int SCORE_W = 6
);

   logic               onesec_enable;
   logic               power_done;
   logic               throw_done;
   logic [1:0]         pins_down;
   logic               new_game;
   game_state_t        game_state;
   logic               round_reset;
   logic [2:0]         rand_target;
   logic [3:0]         frame;
   logic [SCORE_W-1:0] score;
   logic               strike;

   modport master (
      output onesec_enable, power_done, throw_done, pins_down, new_game,
      input  game_state, round_reset, rand_target, frame, score, strike
   );

   modport slave (
      input  onesec_enable, power_done, throw_done, pins_down, new_game,
      output game_state, round_reset, rand_target, frame, score, strike
   );

endinterface

// File: rtl/target_rotator.sv
// 3-bit one-hot target lane register: seeded on reset/new game, rotated
// left once per completed throw. Starting from a one-hot seed it can
// never reach 000.
module target_rotator
   import bowling_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       load,
   input  logic       advance,
   output logic [2:0] target
);

   // Seed load has priority over rotation.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         target <= TARGET_SEED;
      end else if (load) begin
         target <= TARGET_SEED;
      end else if (advance) begin
         target <= {target[1:0], target[2]};
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// Round/frame sequencer: steps each throw through aim/power entry, pin
// resolution and settle, then the one-cycle score update; issues the
// round_reset re-arm pulse and the target lane for the next round.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// AIMPOWER    | waiting for power_done (aim and power final)
// CALCULATE   | throw phase: waiting for throw_done;
//             | settle phase: counting onesec ticks while pins clear
// UPDATE_GAME | one cycle: score/frame/target update, round_reset pulse
// GAME_OVER   | all frames thrown; only new_game is honoured
module game_sequencer
   import bowling_pkg::*;
#(
   parameter int NUM_FRAMES   = 10,
   parameter int SETTLE_TICKS = 2,
   parameter int SCORE_W      = 6
)(
   input  logic             CLOCK_50,
   input  logic             reset,
   game_sequencer_if.slave  bus
);

   localparam int CNT_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS + 1) : 1;
   localparam int SUM_W = SCORE_W + 3;
   localparam logic [SUM_W-1:0] SCORE_MAX = {3'b000, {SCORE_W{1'b1}}};

   game_state_t        state_q, state_d;
   logic               settle_q, settle_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         pins_q, pins_d;
   logic [SCORE_W-1:0] score_q;
   logic [3:0]         frame_q;
   logic               round_reset_q;
   logic               strike_q;

   logic               tick_last;
   logic [3:0]         frame_next;
   logic [SUM_W-1:0]   score_sum;
   logic [SCORE_W-1:0] score_next;

   assign tick_last  = (int'(cnt_q) == SETTLE_TICKS - 1);
   assign frame_next = frame_q + 4'd1;
   assign score_sum  = {3'b000, score_q} + SUM_W'(pins_q)
                     + ((pins_q == STRIKE_PINS) ? SUM_W'(STRIKE_BONUS) : '0);
   assign score_next = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}}
                                               : score_sum[SCORE_W-1:0];

   // Next-state logic; new_game overrides every other event in the cycle.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      cnt_d    = cnt_q;
      pins_d   = pins_q;
      if (bus.new_game) begin
         state_d  = AIMPOWER;
         settle_d = 1'b0;
         cnt_d    = '0;
         pins_d   = '0;
      end else begin
         case (state_q)
            AIMPOWER: begin
               if (bus.power_done) begin
                  state_d  = CALCULATE;
                  settle_d = 1'b0;
               end
            end
            CALCULATE: begin
               if (!settle_q) begin
                  // A tick coincident with throw_done is deliberately not counted.
                  if (bus.throw_done) begin
                     pins_d = bus.pins_down;
                     cnt_d  = '0;
                     if (SETTLE_TICKS == 0) begin
                        state_d = UPDATE_GAME;
                     end else begin
                        settle_d = 1'b1;
                     end
                  end
               end else if (bus.onesec_enable) begin
                  if (tick_last) begin
                     state_d  = UPDATE_GAME;
                     settle_d = 1'b0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            UPDATE_GAME: begin
               state_d = (frame_next == 4'(NUM_FRAMES)) ? GAME_OVER : AIMPOWER;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // FSM, settle counter and latched pin count.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q  <= AIMPOWER;
         settle_q <= 1'b0;
         cnt_q    <= '0;
         pins_q   <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         cnt_q    <= cnt_d;
         pins_q   <= pins_d;
      end
   end

   // Score/frame registers and the pulses, registered so they coincide
   // with the UPDATE_GAME state cycle.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         score_q       <= '0;
         frame_q       <= '0;
         round_reset_q <= 1'b0;
         strike_q      <= 1'b0;
      end else begin
         round_reset_q <= bus.new_game || (state_d == UPDATE_GAME);
         strike_q      <= !bus.new_game && (state_d == UPDATE_GAME)
                          && (pins_d == STRIKE_PINS);
         if (bus.new_game) begin
            score_q <= '0;
            frame_q <= '0;
         end else if (state_q == UPDATE_GAME) begin
            score_q <= score_next;
            frame_q <= frame_next;
         end
      end
   end

   target_rotator u_target_rotator (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .load     (bus.new_game),
      .advance  (!bus.new_game && (state_q == UPDATE_GAME)),
      .target   (bus.rand_target)
   );

   assign bus.game_state  = state_q;
   assign bus.round_reset = round_reset_q;
   assign bus.strike      = strike_q;
   assign bus.score       = score_q;
   assign bus.frame       = frame_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a vector table for the single-throw,
// strike and illegal-input cases, plus hand sequences for async reset,
// the full game, new_game and score saturation.
module tb_game_sequencer;
   import bowling_pkg::*;

   logic CLOCK_50 = 1'b0;
   logic reset;
   always #10 CLOCK_50 = ~CLOCK_50;

   game_sequencer_if #(.SCORE_W(6)) gi ();
   game_sequencer_if #(.SCORE_W(3)) si ();

   game_sequencer #(.NUM_FRAMES(10), .SETTLE_TICKS(2), .SCORE_W(6)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (gi)
   );

   game_sequencer #(.NUM_FRAMES(3), .SETTLE_TICKS(0), .SCORE_W(3)) dut_sat (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (si)
   );

   typedef struct {
      logic       pw, th;
      logic [1:0] pins;
      logic       tk, ng;
      int         st, rr, sk, sc, fr, tg;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic drive(input logic pw, input logic th, input logic [1:0] pins,
                        input logic tk, input logic ng);
      gi.power_done    = pw;
      gi.throw_done    = th;
      gi.pins_down     = pins;
      gi.onesec_enable = tk;
      gi.new_game      = ng;
      cyc();
      gi.power_done    = 1'b0;
      gi.throw_done    = 1'b0;
      gi.pins_down     = 2'd0;
      gi.onesec_enable = 1'b0;
      gi.new_game      = 1'b0;
   endtask

   task automatic drive_sat(input logic pw, input logic th, input logic [1:0] pins);
      si.power_done = pw;
      si.throw_done = th;
      si.pins_down  = pins;
      cyc();
      si.power_done = 1'b0;
      si.throw_done = 1'b0;
      si.pins_down  = 2'd0;
   endtask

   task automatic check_main(input string tag, input int st, input int rr, input int sk,
                             input int sc, input int fr, input int tg);
      check({tag, "_state"},  int'(gi.game_state),  st);
      check({tag, "_rreset"}, int'(gi.round_reset), rr);
      check({tag, "_strike"}, int'(gi.strike),      sk);
      check({tag, "_score"},  int'(gi.score),       sc);
      check({tag, "_frame"},  int'(gi.frame),       fr);
      check({tag, "_target"}, int'(gi.rand_target), tg);
   endtask

   function automatic vec_t mk(input logic pw, input logic th, input logic [1:0] pins,
                               input logic tk, input logic ng, input int st, input int rr,
                               input int sk, input int sc, input int fr, input int tg);
      vec_t v;
      v.pw = pw; v.th = th; v.pins = pins; v.tk = tk; v.ng = ng;
      v.st = st; v.rr = rr; v.sk = sk; v.sc = sc; v.fr = fr; v.tg = tg;
      return v;
   endfunction

   initial begin
      int exp_tg[3];
      exp_tg[0] = 3'b010;
      exp_tg[1] = 3'b100;
      exp_tg[2] = 3'b001;

      // single throw of 2 pins, two settle ticks
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'b010));
      vecs.push_back(mk(0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 3'b010));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 3'b010));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'b010));
      vecs.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0, 0, 0, 3'b010));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 3'b100));
      // strike; tick coincident with throw_done is not counted
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 2, 1, 3'b100));
      vecs.push_back(mk(0, 1, 3, 1, 0, 1, 0, 0, 2, 1, 3'b100));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 2, 1, 3'b100));
      vecs.push_back(mk(0, 0, 0, 1, 0, 2, 1, 1, 2, 1, 3'b100));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 2, 3'b001));
      // illegal throw in AIMPOWER, repeated power_done, tick in throw phase
      vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 6, 2, 3'b001));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 6, 2, 3'b001));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 6, 2, 3'b001));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 6, 2, 3'b001));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 6, 2, 3'b001));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 6, 2, 3'b001));
      vecs.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0, 6, 2, 3'b001));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 3, 3'b010));

      reset = 1'b0;
      gi.power_done = 0; gi.throw_done = 0; gi.pins_down = 0;
      gi.onesec_enable = 0; gi.new_game = 0;
      si.power_done = 0; si.throw_done = 0; si.pins_down = 0;
      si.onesec_enable = 0; si.new_game = 0;
      cyc();
      cyc();
      check_main("reset", 0, 0, 0, 0, 0, 3'b010);
      reset = 1'b1;
      cyc();

      // idle with stray throw_done pulses
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 2'(i + 1), 0, 0);
         check($sformatf("idle%0d_state", i), int'(gi.game_state), 0);
      end

      foreach (vecs[i]) begin
         drive(vecs[i].pw, vecs[i].th, vecs[i].pins, vecs[i].tk, vecs[i].ng);
         check_main($sformatf("row%0d", i), vecs[i].st, vecs[i].rr, vecs[i].sk,
                    vecs[i].sc, vecs[i].fr, vecs[i].tg);
      end

      // asynchronous reset in the settle phase
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 2, 0, 0);
      drive(0, 0, 0, 1, 0);
      reset = 1'b0;
      #1;
      check_main("async_rst", 0, 0, 0, 0, 0, 3'b010);
      cyc();
      check("async_rst_hold_rreset", int'(gi.round_reset), 0);
      reset = 1'b1;
      cyc();

      // full game of ten strikes
      for (int k = 1; k <= 10; k++) begin
         drive(1, 0, 0, 0, 0);
         drive(0, 1, 3, 0, 0);
         drive(0, 0, 0, 1, 0);
         drive(0, 0, 0, 1, 0);
         check($sformatf("game%0d_upd_state", k), int'(gi.game_state), 2);
         check($sformatf("game%0d_strike", k), int'(gi.strike), 1);
         drive(0, 0, 0, 0, 0);
         check_main($sformatf("game%0d", k), (k == 10) ? 3 : 0, 0, 0, 4 * k, k,
                    exp_tg[k % 3]);
      end

      // GAME_OVER ignores everything except new_game
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 3, 1, 0);
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      check_main("over_hold", 3, 0, 0, 40, 10, 3'b100);

      drive(0, 0, 0, 0, 1);
      check_main("ng_over", 0, 1, 0, 0, 0, 3'b010);

      // new_game in the settle phase, coincident with the final tick
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 3, 0, 0);
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 1);
      check_main("ng_settle", 0, 1, 0, 0, 0, 3'b010);
      drive(0, 0, 0, 0, 0);
      check_main("ng_after", 0, 0, 0, 0, 0, 3'b010);

      // saturation instance: SCORE_W=3, NUM_FRAMES=3, SETTLE_TICKS=0
      for (int k = 1; k <= 3; k++) begin
         drive_sat(1, 0, 0);
         drive_sat(0, 1, 3);
         check($sformatf("sat%0d_upd_state", k), int'(si.game_state), 2);
         check($sformatf("sat%0d_strike", k), int'(si.strike), 1);
         drive_sat(0, 0, 0);
         check($sformatf("sat%0d_score", k), int'(si.score), (k == 1) ? 4 : 7);
         check($sformatf("sat%0d_frame", k), int'(si.frame), k);
         check($sformatf("sat%0d_state", k), int'(si.game_state), (k == 3) ? 3 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Round/frame sequencer for the bowling game. It walks each throw through aim/power entry, the pin-resolution and settle phase, and the score update. It generates the one-cycle `round_reset` that re-arms the aim, power and pin stages, and supplies the next `rand_target`. It sits downstream of the pin stage, consuming its per-throw result, and drives the score display path and the round restart of every upstream stage.

## Interface
Parameters:
- `NUM_FRAMES`, 10: throws per game.
- `SETTLE_TICKS`, 2: `onesec_enable` ticks to hold after a throw resolves, while pins clear.
- `SCORE_W`, 6: score width. Must hold 4·NUM_FRAMES.

Ports:
- `CLOCK_50`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `onesec_enable`  in  1  one-cycle tick from the one-second counter.
- `power_done`  in  1  one-cycle pulse: power level released; aim and power are final.
- `throw_done`  in  1  one-cycle pulse from the pin stage: throw resolved.
- `pins_down`  in  2  pins knocked this throw (0–3); valid with `throw_done`.
- `new_game`  in  1  one-cycle pulse: restart the game.
- `game_state`  out  2  AIMPOWER=00, CALCULATE=01, UPDATE_GAME=10, GAME_OVER=11.
- `round_reset`  out  1  one-cycle re-arm pulse to the aim, power and pin stages.
- `rand_target`  out  3  target lane for the current round.
- `frame`  out  4  completed throws, 0..NUM_FRAMES.
- `score`  out  SCORE_W  running total.
- `strike`  out  1  one-cycle pulse on a 3-pin throw.

## Operation
- **AIMPOWER**: wait for `power_done`, then go to CALCULATE. All other inputs are ignored.
- **CALCULATE, throw phase**: wait for `throw_done`. On it:
  - latch `pins_down` into `pins_q`;
  - clear the settle counter;
  - enter the settle phase.
- **CALCULATE, settle phase**: count `onesec_enable` ticks. When the count reaches SETTLE_TICKS, go to UPDATE_GAME.
  - With SETTLE_TICKS=0, go directly to UPDATE_GAME the cycle after `throw_done`.
  - A tick in the same cycle as `throw_done` is not counted.
- **UPDATE_GAME** (exactly one cycle):
  - `score += pins_q + (pins_q==3 ? 1 : 0)`, saturating at all-ones;
  - `frame += 1`;
  - rotate `rand_target` left by one;
  - `round_reset` = 1 and, if `pins_q`==3, `strike` = 1.
  - Next state: GAME_OVER if the new `frame`==NUM_FRAMES, else AIMPOWER.
- **GAME_OVER**: hold `score` and `frame`. Ignore everything except `new_game`.
- **`new_game`**: honoured in every state, with priority over all other events that cycle:
  - clear `score`, `frame`, `pins_q` and the settle counter;
  - reload `rand_target`=3'b010;
  - go to AIMPOWER;
  - pulse `round_reset` for one cycle. `strike` stays 0.
- **`rand_target` sequence**: 010 → 100 → 001 → 010. It never reaches 000.
- **Illegal input**: a `throw_done` outside the CALCULATE throw phase is ignored, and so is a repeated `power_done`.

## Timing
- **Reset values**: `game_state`=00, `round_reset`=0, `strike`=0, `rand_target`=3'b010, `frame`=0, `score`=0. The settle counter and `pins_q` also reset to 0.
- All outputs are registered. `round_reset` and `strike` are high during the same cycle in which `game_state`==UPDATE_GAME.
- The updated `score`, `frame` and `rand_target` are visible in the cycle after UPDATE_GAME.
- **`power_done` at cycle t**: CALCULATE from t+1.
- **`throw_done` at cycle t**: the earliest UPDATE_GAME is at t+1 (SETTLE_TICKS=0). Otherwise it is one cycle after the SETTLE_TICKS-th subsequent tick.
- **Reset mid-round**: returns to the reset values immediately (asynchronous); `round_reset` is not pulsed.
- **Saturation**: `score` holds at 2^SCORE_W−1 and never wraps.

## Structure
- Package `bowling_pkg`:
  - `game_state_t` enum (AIMPOWER, CALCULATE, UPDATE_GAME, GAME_OVER);
  - constants `TARGET_SEED`=3'b010 and `STRIKE_PINS`=3;
  - `STRIKE_BONUS`=1.
  - The aim, power and pin stages share this state encoding.
- One sub-module, `target_rotator`: a 3-bit rotate register with seed load and advance enable, driven by the UPDATE_GAME and `new_game` conditions.
- Everything else (FSM, settle counter, score/frame registers) lives in `game_sequencer`.

## Test plan
- **Reset, then idle**: all outputs at their reset values. Random `throw_done` pulses in AIMPOWER leave the state at 00.
- **Single throw**:
  - stimulus: `power_done`, `throw_done` with `pins_down`=2, SETTLE_TICKS=2, two ticks;
  - response: one `round_reset` pulse, `score`=2, `frame`=1, `rand_target`=3'b100, `strike`=0, state back to 00.
- **Strike**:
  - stimulus: a throw with `pins_down`=3;
  - response: `strike` pulse, `score` +4.
  - A `throw_done` in the same cycle as a tick gives settle=2 only after two later ticks.
- **Full game**:
  - stimulus: 10 throws of 3 pins;
  - response: `score`=40, `frame`=10, state 11, `rand_target` back at 3'b100 after ten rotations.
  - Further `power_done`/`throw_done` pulses have no effect.
- **`new_game` during the CALCULATE settle phase**: next cycle state 00, `score`=0, `frame`=0, `rand_target`=3'b010, one `round_reset` pulse, no `strike`.
- **Saturation**: with SCORE_W=3, NUM_FRAMES=3 and three strikes, `score` sticks at 7.
